bram_ptr_streamer: RTL and testbench
====================================

Name: bram_ptr_streamer

Overview:
- Playback engine between the 512-bit BRAM read port and the 512-bit AXI4-Stream DAC feed.
- When enabled, reads BRAM words from start pointer up to (not including) stop pointer, emits them on the master AXIS, then wraps back to start.
- Enable and pointers come from the DAC/start/stop AXI GPIO outputs.
- Honours tready back-pressure without dropping or duplicating words, despite the fixed BRAM read latency.

Parameters:
- DATA_W, 512, AXIS/BRAM data width in bits.
- ADDR_W, 32, BRAM byte-address width.
- PTR_W, 32, start/stop pointer width.
- BRAM_LAT, 2, BRAM read latency in cycles from bram_en to valid bram_dout.
- FIFO_DEPTH, BRAM_LAT+2, depth of the output skid FIFO in words.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  synchronous, active-low reset.
- enable  in  1  GPIO DAC bit 0; level-sensitive run request.
- start_ptr  in  PTR_W  byte address of first word; bits [5:0] ignored.
- stop_ptr  in  PTR_W  byte address one past last word, exclusive; bits [5:0] ignored.
- bram_addr  out  ADDR_W  BRAM byte address, always 64-byte aligned.
- bram_en  out  1  BRAM read enable.
- bram_dout  in  DATA_W  BRAM read data.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- busy  out  1  high in any state other than IDLE.
- pass_count  out  16  number of completed passes; wraps at 0xFFFF.
- range_err  out  1  sticky flag; set when a run is requested with stop word <= start word.

Behaviour:
- Reset values: bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, pass_count=0, range_err=0, FIFO empty, state=IDLE.
- Word index = ptr[PTR_W-1:6]. Address arithmetic uses word indices; bram_addr = {word,6'b0}.
- IDLE:
  - On enable=1, latch start/stop words.
  - If stop word > start word: go to RUN with rd_word=start.
  - Else: set range_err and stay in IDLE.
  - range_err clears only on reset.
- RUN:
  - Issue a read (bram_en=1) in a cycle only if in_flight + fifo_count < FIFO_DEPTH.
  - After the read of word stop-1: rd_word := start, pass_count increments on that issue cycle, and pointers are re-latched from the inputs for the next pass.
  - Pointer changes mid-pass take effect only at a wrap.
- On enable=0 in RUN: go to DRAIN and issue no further reads.
- DRAIN: in-flight reads land and the FIFO empties through AXIS; then go to IDLE. Enable reasserted during DRAIN is ignored until IDLE is reached.
- Read pipeline: a BRAM_LAT-deep valid shift register tracks reads in flight. When a bit exits, bram_dout is pushed to the FIFO. The credit rule guarantees no overflow.
- AXIS rules:
  - tvalid = FIFO non-empty; tdata = FIFO head.
  - A pop happens when tvalid && tready.
  - tvalid never drops without a handshake; tdata is stable while tvalid=1 and tready=0.
  - Simultaneous push and pop is allowed, including with the FIFO full.
- Throughput: with tready held high, one word per cycle sustained.
- First-word latency: enable rising to first tvalid = BRAM_LAT+1 cycles.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight data is discarded.

Optional Feature:
- Macro: BRAM_PTR_STREAMER_TLAST_EN.
- When defined:
  - Adds output port m_axis_tlast (1 bit).
  - tlast is carried through the FIFO alongside data.
  - tlast is asserted on the word read from address stop-1 of every pass.
- When undefined:
  - No tlast port, no extra FIFO bit.
  - The stream is continuous and packet-less.

Decomposition:
- Package bram_ptr_streamer_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN};
  - WORD_BYTES=64, WORD_SHIFT=6;
  - default width constants.
- Sub-module axis_skid_fifo: synchronous FIFO of FIFO_DEPTH words with count output, AXIS-style pop side, registered head.
- The top level holds the FSM, address counter, and in-flight shift register.

Test Plan:
- Load words 0 and 1 at byte addresses 0x0 and 0x40; start=0x0, stop=0x80, tready=1, enable=1 -> stream 0,1,0,1,...; pass_count increments every 2 words; first tvalid 3 cycles after enable (BRAM_LAT=2).
- Same setup with tready toggling 1-0-0-1 pseudo-randomly for 200 cycles -> received sequence is the exact repeating 0,1 pattern; no gaps or duplicates; tdata stable while stalled.
- start=0x0, stop=0x0, enable=1 -> range_err=1, busy=0, bram_en never asserted.
- Mid-pass, change stop from 0x80 to 0xC0 -> new range applies only after the next wrap; word 2 appears only after a complete 0,1 pass.
- Deassert enable with tready=0 and FIFO full -> no new bram_en; after tready=1, exactly the queued plus in-flight words are emitted, then busy=0.
- With BRAM_PTR_STREAMER_TLAST_EN defined, start=0x40, stop=0x100 -> tlast high on every word from address 0xC0 only; aresetn pulsed mid-stream -> tvalid=0 on the next cycle and pass_count=0.

Source files
------------

// File: rtl/bram_ptr_streamer_pkg.sv
// -----------------------------------------------------------------------------
// bram_ptr_streamer_pkg
//   Shared types and constants for the BRAM pointer streamer.
//   - state_t      : playback FSM states (IDLE, RUN, DRAIN)
//   - WORD_BYTES   : bytes per BRAM/AXIS word (512-bit words)
//   - WORD_SHIFT   : byte-address to word-index shift
//   - DEF_*        : default widths/latency used as top-level parameter defaults
// -----------------------------------------------------------------------------
package bram_ptr_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WORD_BYTES = 64;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  localparam int DEF_DATA_W   = 512;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_PTR_W    = 32;
  localparam int DEF_BRAM_LAT = 2;

endpackage : bram_ptr_streamer_pkg

// File: rtl/bram_ptr_streamer_if.sv
// -----------------------------------------------------------------------------
// bram_ptr_streamer_if
//   AXI4-Stream style bundle carrying the playback stream.
//   Signals: tdata, tvalid, tready, and tlast when BRAM_PTR_STREAMER_TLAST_EN
//   is defined.
//   Modports: master (source: drives tdata/tvalid[/tlast], reads tready)
//             slave  (sink:   reads tdata/tvalid[/tlast], drives tready)
//   DATA_W must match the DATA_W of the streamer it is connected to.
// -----------------------------------------------------------------------------
interface bram_ptr_streamer_if #(
  parameter int DATA_W = 512
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
`ifdef BRAM_PTR_STREAMER_TLAST_EN
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif

endinterface : bram_ptr_streamer_if

// File: rtl/bram_ptr_streamer_axis_skid_fifo.sv
// -----------------------------------------------------------------------------
// axis_skid_fifo
//   Small synchronous FIFO with a registered head entry and an AXIS-style
//   pop side. Entries shift toward the head on every pop, so out_data is
//   always straight from a flop.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     push, din   : write side; caller guarantees room (count < DEPTH, or a
//                   pop in the same cycle)
//     out_valid   : FIFO non-empty
//     out_ready   : consumer ready; pop = out_valid && out_ready
//     out_data    : head entry, stable until popped
//     count       : current occupancy
// -----------------------------------------------------------------------------
module axis_skid_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_pos;
  logic [W-1:0]     head_q;
  logic [W-1:0]     tail_q [DEPTH-1];
  logic [W-1:0]     slot   [DEPTH];
  logic [W-1:0]     slot_d [DEPTH];
  logic             pop;

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign pop       = out_valid && out_ready;

  // Flat view of the storage: slot 0 is the head register.
  always_comb begin
    slot[0] = head_q;
    for (int i = 1; i < DEPTH; i++) begin
      slot[i] = tail_q[i-1];
    end
  end

  // On a pop everything moves one place toward the head; a push lands just
  // behind the last surviving entry, which makes push+pop on a full FIFO work.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    slot_d  = slot;
    count_d = count_q;
    wr_pos  = pop ? (count_q - CNT_W'(1)) : count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i] = slot[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_pos == CNT_W'(i)) begin
          slot_d[i] = din;
        end
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= slot_d[0];
    end
  end

  // NOTE: the tail storage is deliberately not reset; count_q alone decides validity.
  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      tail_q[i-1] <= slot_d[i];
    end
  end

endmodule : axis_skid_fifo

// File: rtl/bram_ptr_streamer.sv
// -----------------------------------------------------------------------------
// bram_ptr_streamer
//   Plays a window of 512-bit BRAM words [start, stop) onto an AXI4-Stream
//   master, wrapping back to start after each pass, while enable is high.
//   Reads are credit-limited so that every word in flight through the fixed
//   BRAM latency always has a FIFO slot waiting, making back-pressure lossless.
//
//   Ports:
//     aclk, aresetn       : clock, synchronous active-low reset
//     enable              : level-sensitive run request
//     start_ptr, stop_ptr : byte pointers (bits [5:0] ignored), stop exclusive
//     bram_addr, bram_en  : BRAM read port request (64-byte aligned address)
//     bram_dout           : BRAM read data, valid BRAM_LAT cycles after bram_en
//     m_axis              : stream master (tdata/tvalid/tready[/tlast])
//     busy                : FSM not in IDLE
//     pass_count          : completed passes (counted when the last read issues)
//     range_err           : sticky, set when a run sees stop word <= start word
//
//   Build option: define BRAM_PTR_STREAMER_TLAST_EN to add m_axis.tlast, set
//   on the word read from stop-1 of every pass.
// -----------------------------------------------------------------------------
module bram_ptr_streamer
  import bram_ptr_streamer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PTR_W      = DEF_PTR_W,
  parameter int BRAM_LAT   = DEF_BRAM_LAT,
  parameter int FIFO_DEPTH = BRAM_LAT + 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [PTR_W-1:0]      start_ptr,
  input  logic [PTR_W-1:0]      stop_ptr,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_en,
  input  logic [DATA_W-1:0]     bram_dout,
  bram_ptr_streamer_if.master   m_axis,
  output logic                  busy,
  output logic [15:0]           pass_count,
  output logic                  range_err
);

  localparam int WORD_W = PTR_W - WORD_SHIFT;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   start_word_q, stop_word_q, rd_word_q;
  logic [WORD_W-1:0]   start_word_in, stop_word_in, last_word;
  logic [BRAM_LAT-1:0] inflight_q;
  logic [15:0]         pass_count_q;
  logic                range_err_q;
  logic [CNT_W-1:0]    fifo_count;
  logic [PTR_W-1:0]    addr_full;
  logic                range_ok_in;
  logic                credit_ok;
  logic                issue;
  logic                last_issue;
  logic                drained;
  logic                push;

  // Only the word index of each pointer matters.
  logic unused_ptr_lsbs;
  assign unused_ptr_lsbs = ^{start_ptr[WORD_SHIFT-1:0], stop_ptr[WORD_SHIFT-1:0]};

  assign start_word_in = start_ptr[PTR_W-1:WORD_SHIFT];
  assign stop_word_in  = stop_ptr[PTR_W-1:WORD_SHIFT];
  assign range_ok_in   = (stop_word_in > start_word_in);
  assign last_word     = stop_word_q - WORD_W'(1);

  // A read may issue only if every word already promised (in flight or
  // queued) plus this one still fits in the FIFO.
  assign credit_ok  = (int'($countones(inflight_q)) + int'(fifo_count)) < FIFO_DEPTH;
  assign issue      = (state_q == RUN) && enable && credit_ok;
  assign last_issue = issue && (rd_word_q == last_word);
  assign drained    = (inflight_q == '0) && (fifo_count == '0);
  assign push       = inflight_q[BRAM_LAT-1];

  assign addr_full  = {rd_word_q, {WORD_SHIFT{1'b0}}};
  assign bram_addr  = ADDR_W'(addr_full);
  assign bram_en    = issue;
  assign busy       = (state_q != IDLE);
  assign pass_count = pass_count_q;
  assign range_err  = range_err_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && range_ok_in) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A wrap that picks up an invalid window stops the run cleanly.
        if (!enable || (last_issue && !range_ok_in)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, pass counter, error flag and in-flight tracker
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_word_q <= '0;
      stop_word_q  <= '0;
      rd_word_q    <= '0;
      pass_count_q <= '0;
      range_err_q  <= 1'b0;
      inflight_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            start_word_q <= start_word_in;
            stop_word_q  <= stop_word_in;
            if (range_ok_in) begin
              rd_word_q <= start_word_in;
            end else begin
              range_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) begin
            // Pointer updates from the GPIOs are only picked up here.
            start_word_q <= start_word_in;
            stop_word_q  <= stop_word_in;
            rd_word_q    <= start_word_in;
            pass_count_q <= pass_count_q + 16'd1;
            if (!range_ok_in) begin
              range_err_q <= 1'b1;
            end
          end else if (issue) begin
            rd_word_q <= rd_word_q + WORD_W'(1);
          end
        end
        default: ;
      endcase
      inflight_q <= (inflight_q << 1) | BRAM_LAT'(issue);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
`ifdef BRAM_PTR_STREAMER_TLAST_EN
  localparam int ENTRY_W = DATA_W + 1;
  logic [BRAM_LAT-1:0] last_q;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;

  // tlast rides alongside the in-flight bit for the read that closed a pass.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_q <= '0;
    end else begin
      last_q <= (last_q << 1) | BRAM_LAT'(last_issue);
    end
  end

  assign fifo_din     = {last_q[BRAM_LAT-1], bram_dout};
  assign m_axis.tlast = fifo_dout[DATA_W];
`else
  localparam int ENTRY_W = DATA_W;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;

  assign fifo_din = bram_dout;
`endif

  assign m_axis.tdata = fifo_dout[DATA_W-1:0];

  axis_skid_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push),
    .din       (fifo_din),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (fifo_dout),
    .count     (fifo_count)
  );

endmodule : bram_ptr_streamer

// File: tb/tb_bram_ptr_streamer.sv
// -----------------------------------------------------------------------------
// tb_bram_ptr_streamer
//   Directed bench for bram_ptr_streamer with a 2-cycle BRAM model, a stream
//   monitor on the falling edge, and hand-computed expected word sequences.
// -----------------------------------------------------------------------------
module tb_bram_ptr_streamer;

  localparam int DATA_W = 512;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              enable;
  logic [31:0]       start_ptr;
  logic [31:0]       stop_ptr;
  logic [31:0]       bram_addr;
  logic              bram_en;
  logic [DATA_W-1:0] bram_dout;
  logic              tready;
  logic              busy;
  logic [15:0]       pass_count;
  logic              range_err;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  logic [DATA_W-1:0] rx_q[$];
  logic              rx_last[$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;

  logic [DATA_W-1:0] mem [8];
  logic [DATA_W-1:0] stage1, stage2;

  int exp_t4 [10] = '{0, 1, 0, 1, 0, 1, 2, 0, 1, 2};
  int exp_t6 [6]  = '{1, 2, 3, 1, 2, 3};

  always #5 aclk = ~aclk;

  bram_ptr_streamer_if #(.DATA_W(DATA_W)) m_axis_if ();
  assign m_axis_if.tready = tready;

  bram_ptr_streamer dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .start_ptr  (start_ptr),
    .stop_ptr   (stop_ptr),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_dout  (bram_dout),
    .m_axis     (m_axis_if),
    .busy       (busy),
    .pass_count (pass_count),
    .range_err  (range_err)
  );

  // Distinct content per word and per 32-bit lane.
  function automatic logic [DATA_W-1:0] word_val(input int idx);
    logic [DATA_W-1:0] v;
    for (int j = 0; j < 16; j++) begin
      v[j*32 +: 32] = 32'hC0DE_0000 + 32'(idx * 16 + j);
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // BRAM read port, latency 2 from bram_en to bram_dout.
  always @(posedge aclk) begin
    if (bram_en) stage1 <= mem[bram_addr[8:6]];
    stage2 <= stage1;
  end
  assign bram_dout = stage2;

  // Stream monitor: capture handshakes, check hold-while-stalled, count reads.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (bram_en) begin
        en_count++;
        check("addr_align", DATA_W'(bram_addr[5:0]), '0);
      end
      if (prev_stall) begin
        check("stall_tvalid", DATA_W'(m_axis_if.tvalid), DATA_W'(1));
        check("stall_tdata", m_axis_if.tdata, prev_data);
      end
      if (m_axis_if.tvalid && tready) begin
        rx_q.push_back(m_axis_if.tdata);
`ifdef BRAM_PTR_STREAMER_TLAST_EN
        rx_last.push_back(m_axis_if.tlast);
`else
        rx_last.push_back(1'b0);
`endif
      end
      prev_stall = m_axis_if.tvalid && !tready;
      prev_data  = m_axis_if.tdata;
    end
  end

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    rx_q.delete();
    rx_last.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (!busy) break;
    end
    check(tag, DATA_W'(busy), '0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = word_val(i);
    aresetn   = 1'b0;
    enable    = 1'b0;
    start_ptr = '0;
    stop_ptr  = '0;
    tready    = 1'b0;

    // ---- reset state ----
    do_reset();
    check("rst_bram_en", DATA_W'(bram_en), '0);
    check("rst_bram_addr", DATA_W'(bram_addr), '0);
    check("rst_tvalid", DATA_W'(m_axis_if.tvalid), '0);
    check("rst_tdata", m_axis_if.tdata, '0);
    check("rst_busy", DATA_W'(busy), '0);
    check("rst_pass", DATA_W'(pass_count), '0);
    check("rst_range_err", DATA_W'(range_err), '0);

    // ---- T1: 0,1 loop, tready high, latency and pass counting ----
    start_ptr = 32'h0;
    stop_ptr  = 32'h80;
    tready    = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    @(posedge aclk); #1;  // edge that samples enable
    check("t1_busy", DATA_W'(busy), DATA_W'(1));
    check("t1_e0_tvalid", DATA_W'(m_axis_if.tvalid), '0);
    check("t1_e0_bram_en", DATA_W'(bram_en), DATA_W'(1));
    check("t1_e0_addr", DATA_W'(bram_addr), '0);
    @(posedge aclk); #1;
    check("t1_e1_tvalid", DATA_W'(m_axis_if.tvalid), '0);
    check("t1_e1_addr", DATA_W'(bram_addr), DATA_W'(32'h40));
    check("t1_e1_pass", DATA_W'(pass_count), '0);
    @(posedge aclk); #1;
    check("t1_e2_tvalid", DATA_W'(m_axis_if.tvalid), '0);
    check("t1_e2_pass", DATA_W'(pass_count), DATA_W'(1));
    @(posedge aclk); #1;  // third edge after the sampling edge
    check("t1_e3_tvalid", DATA_W'(m_axis_if.tvalid), DATA_W'(1));
    check("t1_e3_tdata", m_axis_if.tdata, word_val(0));
    @(posedge aclk); #1;
    check("t1_e4_pass", DATA_W'(pass_count), DATA_W'(2));
    repeat (20) @(negedge aclk);
    enable = 1'b0;
    wait_idle("t1_idle");
    check("t1_rx_enough", DATA_W'(rx_q.size() >= 20), DATA_W'(1));
    for (int k = 0; k < rx_q.size(); k++) check("t1_seq", rx_q[k], word_val(k % 2));
    check("t1_pass_vs_words", DATA_W'(pass_count), DATA_W'(rx_q.size() / 2));

    // ---- T2: random back-pressure ----
    do_reset();
    start_ptr = 32'h0;
    stop_ptr  = 32'h80;
    tready    = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      tready = 1'($urandom_range(0, 1));
    end
    enable = 1'b0;
    tready = 1'b1;
    wait_idle("t2_idle");
    check("t2_rx_enough", DATA_W'(rx_q.size() > 50), DATA_W'(1));
    for (int k = 0; k < rx_q.size(); k++) check("t2_seq", rx_q[k], word_val(k % 2));
    check("t2_pass_vs_words", DATA_W'(pass_count), DATA_W'(rx_q.size() / 2));

    // ---- T4: stop moves 0x80 -> 0xC0 mid-pass ----
    do_reset();
    start_ptr = 32'h0;
    stop_ptr  = 32'h80;
    tready    = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    repeat (3) @(posedge aclk);  // now in the cycle issuing word 0 of pass 2
    @(negedge aclk);
    stop_ptr = 32'hC0;
    repeat (20) @(negedge aclk);
    enable = 1'b0;
    wait_idle("t4_idle");
    check("t4_rx_enough", DATA_W'(rx_q.size() >= 10), DATA_W'(1));
    for (int k = 0; k < 10; k++) check("t4_seq", rx_q[k], word_val(exp_t4[k]));

    // ---- T5: disable while stalled with a full FIFO ----
    do_reset();
    start_ptr = 32'h0;
    stop_ptr  = 32'h80;
    tready    = 1'b0;
    @(negedge aclk);
    enable = 1'b1;
    repeat (10) @(negedge aclk);
    check("t5_full_tvalid", DATA_W'(m_axis_if.tvalid), DATA_W'(1));
    check("t5_full_no_read", DATA_W'(bram_en), '0);
    enable   = 1'b0;
    en_count = 0;
    repeat (5) @(negedge aclk);
    check("t5_no_new_reads", DATA_W'(en_count), '0);
    check("t5_drain_busy", DATA_W'(busy), DATA_W'(1));
    check("t5_head", m_axis_if.tdata, word_val(0));
    tready = 1'b1;
    wait_idle("t5_idle");
    check("t5_rx_count", DATA_W'(rx_q.size()), DATA_W'(4));
    for (int k = 0; k < 4; k++) check("t5_seq", rx_q[k], word_val(k % 2));
    check("t5_tvalid_end", DATA_W'(m_axis_if.tvalid), '0);

    // ---- T3: empty window ----
    do_reset();
    start_ptr = 32'h0;
    stop_ptr  = 32'h0;
    tready    = 1'b1;
    en_count  = 0;
    @(negedge aclk);
    enable = 1'b1;
    repeat (6) @(negedge aclk);
    check("t3_range_err", DATA_W'(range_err), DATA_W'(1));
    check("t3_busy", DATA_W'(busy), '0);
    check("t3_no_reads", DATA_W'(en_count), '0);
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    check("t3_sticky", DATA_W'(range_err), DATA_W'(1));
    do_reset();
    check("t3_rst_clears", DATA_W'(range_err), '0);

    // ---- T6: window 0x40..0x100, tlast on 0xC0, reset mid-stream ----
    start_ptr = 32'h40;
    stop_ptr  = 32'h100;
    tready    = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    repeat (14) @(negedge aclk);
    check("t6_rx_enough", DATA_W'(rx_q.size() >= 6), DATA_W'(1));
    for (int k = 0; k < 6; k++) begin
      check("t6_seq", rx_q[k], word_val(exp_t6[k]));
`ifdef BRAM_PTR_STREAMER_TLAST_EN
      check("t6_tlast", DATA_W'(rx_last[k]), DATA_W'(exp_t6[k] == 3));
`endif
    end
    check("t6_pass_nonzero", DATA_W'(pass_count != 0), DATA_W'(1));
    check("t6_tvalid_pre", DATA_W'(m_axis_if.tvalid), DATA_W'(1));
    aresetn = 1'b0;
    enable  = 1'b0;
    @(posedge aclk); #1;
    check("t6_rst_tvalid", DATA_W'(m_axis_if.tvalid), '0);
    check("t6_rst_pass", DATA_W'(pass_count), '0);
    check("t6_rst_busy", DATA_W'(busy), '0);
    check("t6_rst_bram_en", DATA_W'(bram_en), '0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bram_ptr_streamer
